banked_ram: RTL

Parametrised, synchronous-read banked RAM: the next generation of the structural RAM8…RAM16K family for the Hack memory system. Depth, word width and bank split are set by parameters. Reads are registered with a valid strobe, read-during-write is defined, and an optional post-reset clear engine zeroes every word before the block accepts requests. It sits wherever the Hack CPU or its test harness needs a data RAM larger than a fixed-size structural chip.

---
 rtl/banked_ram.sv | 95 +++++++++
 1 files changed

// File: rtl/banked_ram.sv
// banked_ram: parametrised banked RAM with registered, write-first reads.
// Optional post-reset zero sweep compiled in with RAM_CLEAR_EN.
module banked_ram #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 9,
    parameter int BANK_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic                 busy
);
    localparam int WB    = ADDR_BITS - BANK_BITS;
    localparam int BANKS = 1 << BANK_BITS;
    localparam int BW    = 1 << WB;
    localparam int SB    = BANK_BITS > 0 ? BANK_BITS : 1;
    localparam int SW    = WB > 0 ? WB : 1;

    logic                 we;
    logic [ADDR_BITS-1:0] wa;
    logic [WIDTH-1:0]     wd;
    logic [WIDTH-1:0]     rdata [BANKS];
    logic [WIDTH-1:0]     rd_word;
    logic [SB-1:0]        wbank, rbank;
    logic [SW-1:0]        wword, rword;

    // Degenerate splits (one bank, or one word per bank) collapse the field to zero.
    function automatic logic [SB-1:0] bank_of(input logic [ADDR_BITS-1:0] a);
        return BANK_BITS > 0 ? SB'(a >> WB) : '0;
    endfunction

    function automatic logic [SW-1:0] word_of(input logic [ADDR_BITS-1:0] a);
        return WB > 0 ? SW'(a) : '0;
    endfunction

`ifdef RAM_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t               state;
    logic [ADDR_BITS-1:0] clear_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else if (state == CLEAR) begin
            if (clear_ptr == '1) state <= IDLE;
            else clear_ptr <= clear_ptr + 1'b1;
        end
    end

    assign busy = state == CLEAR;
    assign we   = busy | load;
    assign wa   = busy ? clear_ptr : address;
    assign wd   = busy ? '0 : in;
`else
    assign busy = 1'b0;
    assign we   = load;
    assign wa   = address;
    assign wd   = in;
`endif

    assign wbank = bank_of(wa);
    assign wword = word_of(wa);
    assign rbank = bank_of(address);
    assign rword = word_of(address);

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [BW];
        always_ff @(posedge clk) begin
            if (we && wbank == SB'(b)) mem[wword] <= wd;
        end
        assign rdata[b] = mem[rword];
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BANKS; i++) rd_word |= (rbank == SB'(i)) ? rdata[i] : '0;
    end

    // Reads and writes share one address, so a concurrent load is always a same-word hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en & ~busy;
            if (rd_en & ~busy) out <= load ? in : rd_word;
        end
    end
endmodule
